// File: rtl/fifo_bus_arbiter.sv
// fifo_bus_arbiter
//   Shares the single fifo_if register port between two requesters:
//   m0 = CPU load/store path, m1 = USB debug/loader monitor.
//   Round-robin grant, one transaction in flight, registered strobes toward
//   fifo_if, one-cycle ack pulse (with read data) back to the winner.
//
//   Transaction flow: IDLE -> ISSUE -> ACK (write)
//                     IDLE -> ISSUE -> WAIT (RD_LATENCY cycles) -> ACK (read)
//
// Parameters
//   RD_LATENCY   cycles from fifo read strobe to valid fifo_rdata_i (1..7)
//
// Configuration macro
//   FIFO_ARB_LOCK_EN  when defined, a winner holding mN_lock_i in its ACK cycle
//                     keeps the preference for the next arbitration. When not
//                     defined the lock inputs are ignored (strict alternation).
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   mN_req_i/we_i/addr_i/wdata_i  requester N transaction (held until ack)
//   mN_lock_i                     requester N grant lock
//   mN_ack_o, mN_rdata_o          completion pulse, read data (held to next ack)
//   fifo_sel_o/read_o/write_o     fifo_if select and one-cycle strobes
//   fifo_addr_o, fifo_wdata_o     fifo_if address / write data (0 outside ISSUE)
//   fifo_rdata_i                  fifo_if read data
//   busy_o                        transaction in progress
module fifo_bus_arbiter #(
    parameter int RD_LATENCY = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       m0_req_i,
    input  logic       m0_we_i,
    input  logic [1:0] m0_addr_i,
    input  logic [7:0] m0_wdata_i,
    input  logic       m0_lock_i,
    output logic       m0_ack_o,
    output logic [7:0] m0_rdata_o,
    input  logic       m1_req_i,
    input  logic       m1_we_i,
    input  logic [1:0] m1_addr_i,
    input  logic [7:0] m1_wdata_i,
    input  logic       m1_lock_i,
    output logic       m1_ack_o,
    output logic [7:0] m1_rdata_o,
    output logic       fifo_sel_o,
    output logic       fifo_read_o,
    output logic       fifo_write_o,
    output logic [1:0] fifo_addr_o,
    output logic [7:0] fifo_wdata_o,
    input  logic [7:0] fifo_rdata_i,
    output logic       busy_o
);

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_rd_latency
            $error("fifo_bus_arbiter: RD_LATENCY must be within 1..7");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    typedef struct packed {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
    } req_t;

    state_t          state_q, state_d;
    req_t            lat_q, lat_d;
    req_t [1:0]      req_in;
    logic [1:0]      req_v;
    logic            win_q, win_d;
    logic            pref_q, pref_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            capture;

    logic            sel_q, rd_q, wr_q;
    logic [1:0]      addr_q;
    logic [7:0]      wdata_q;
    logic [1:0]      ack_q;
    logic [1:0][7:0] rdata_q;

    assign req_in[0] = {m0_we_i, m0_addr_i, m0_wdata_i};
    assign req_in[1] = {m1_we_i, m1_addr_i, m1_wdata_i};
    assign req_v     = {m1_req_i, m0_req_i};

`ifdef FIFO_ARB_LOCK_EN
    logic [1:0] lock_v;
    assign lock_v = {m1_lock_i, m0_lock_i};
`else
    logic unused_lock;
    assign unused_lock = m0_lock_i ^ m1_lock_i;
`endif

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        win_d   = win_q;
        pref_d  = pref_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_v) begin
                    // Contention goes to the preferred side; otherwise the
                    // single requester (req_v[1] is 1 only when m1 is alone).
                    win_d   = (&req_v) ? pref_q : req_v[1];
                    lat_d   = req_in[win_d];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_q.we) begin
                    state_d = ACK;
                end else begin
                    cnt_d   = 3'(RD_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    capture = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK: begin
                pref_d  = ~win_q;
`ifdef FIFO_ARB_LOCK_EN
                if (lock_v[win_q]) pref_d = win_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers are loaded from the next-state decode so strobes and
    // acks line up exactly with the ISSUE / ACK cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lat_q   <= '0;
            win_q   <= 1'b0;
            pref_q  <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            win_q   <= win_d;
            pref_q  <= pref_d;
            cnt_q   <= cnt_d;
            sel_q   <= (state_d == ISSUE);
            rd_q    <= (state_d == ISSUE) && !lat_d.we;
            wr_q    <= (state_d == ISSUE) && lat_d.we;
            addr_q  <= (state_d == ISSUE) ? lat_d.addr  : '0;
            wdata_q <= (state_d == ISSUE) ? lat_d.wdata : '0;
            for (int i = 0; i < 2; i++) begin
                ack_q[i] <= (state_d == ACK) && (win_q == 1'(i));
                if ((state_d == ACK) && (win_q == 1'(i)))
                    rdata_q[i] <= capture ? fifo_rdata_i : 8'h00;
            end
        end
    end

    assign fifo_sel_o   = sel_q;
    assign fifo_read_o  = rd_q;
    assign fifo_write_o = wr_q;
    assign fifo_addr_o  = addr_q;
    assign fifo_wdata_o = wdata_q;
    assign m0_ack_o     = ack_q[0];
    assign m1_ack_o     = ack_q[1];
    assign m0_rdata_o   = rdata_q[0];
    assign m1_rdata_o   = rdata_q[1];
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_bus_arbiter.sv
// Bench for fifo_bus_arbiter: directed scenarios with hand-computed pins,
// then randomized traffic, all checked every cycle against a transaction
// schedule model (a grant at cycle c books issue/ack/busy into future slots).
module tb_fifo_bus_arbiter;
    localparam int L    = 3;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    bit   [1:0] r_req, r_we, r_lock;
    logic [1:0] r_addr [2];
    logic [7:0] r_wd [2];
    logic [7:0] fifo_rdata_i;
    logic       m0_ack_o, m1_ack_o, fifo_sel_o, fifo_read_o, fifo_write_o, busy_o;
    logic [7:0] m0_rdata_o, m1_rdata_o, fifo_wdata_o;
    logic [1:0] fifo_addr_o;

    fifo_bus_arbiter #(.RD_LATENCY(L)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(r_req[0]), .m0_we_i(r_we[0]), .m0_addr_i(r_addr[0]),
        .m0_wdata_i(r_wd[0]), .m0_lock_i(r_lock[0]),
        .m0_ack_o(m0_ack_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(r_req[1]), .m1_we_i(r_we[1]), .m1_addr_i(r_addr[1]),
        .m1_wdata_i(r_wd[1]), .m1_lock_i(r_lock[1]),
        .m1_ack_o(m1_ack_o), .m1_rdata_o(m1_rdata_o),
        .fifo_sel_o(fifo_sel_o), .fifo_read_o(fifo_read_o), .fifo_write_o(fifo_write_o),
        .fifo_addr_o(fifo_addr_o), .fifo_wdata_o(fifo_wdata_o),
        .fifo_rdata_i(fifo_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;

    // Schedule model: expected outputs per cycle.
    bit       e_sel [MAXC], e_rd [MAXC], e_wr [MAXC], e_busy [MAXC];
    bit [1:0] e_addr [MAXC], e_ack [MAXC];
    bit [7:0] e_wd [MAXC], e_rdv [MAXC];
    bit [7:0] m_rd [2];
    int       next_free = 0, ack_c = -1, cap_c = -1;
    bit       pref = 1'b0, win = 1'b0;
    bit       granted [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Advance to the next cycle and compare every output with the model.
    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
        for (int s = 0; s < 2; s++)
            if (e_ack[cyc][s]) m_rd[s] = e_rdv[cyc];
        chk("sel",   fifo_sel_o,   e_sel[cyc]);
        chk("read",  fifo_read_o,  e_rd[cyc]);
        chk("write", fifo_write_o, e_wr[cyc]);
        chk("addr",  fifo_addr_o,  e_addr[cyc]);
        chk("wdata", fifo_wdata_o, e_wd[cyc]);
        chk("busy",  busy_o,       e_busy[cyc]);
        chk("ack0",  m0_ack_o,     e_ack[cyc][0]);
        chk("ack1",  m1_ack_o,     e_ack[cyc][1]);
        chk("rdata0", m0_rdata_o,  m_rd[0]);
        chk("rdata1", m1_rdata_o,  m_rd[1]);
    endtask

    // Let the model see this cycle's inputs (arbitration, capture, lock).
    task automatic mdl();
        int  c;
        bit  we;
        c = cyc;
        if (rst_i) return;
        if (c == cap_c) e_rdv[ack_c] = fifo_rdata_i;
        if (c == ack_c) begin
            pref = ~win;
`ifdef FIFO_ARB_LOCK_EN
            if (r_lock[win]) pref = win;
`endif
            granted[win] = 1'b0;
        end
        if (c >= next_free && (r_req != 2'b00)) begin
            win = (r_req == 2'b11) ? pref : r_req[1];
            we  = r_we[win];
            e_sel[c+1]  = 1'b1;
            e_rd[c+1]   = !we;
            e_wr[c+1]   = we;
            e_addr[c+1] = r_addr[win];
            e_wd[c+1]   = r_wd[win];
            ack_c = we ? c + 2 : c + 2 + L;
            cap_c = we ? -1 : c + 1 + L;
            e_rdv[ack_c] = 8'h00;
            e_ack[ack_c][win] = 1'b1;
            for (int j = c + 1; j <= ack_c; j++) e_busy[j] = 1'b1;
            next_free = ack_c + 1;
            granted[win] = 1'b1;
        end
    endtask

    task automatic mdl_reset();
        for (int j = cyc; j < MAXC; j++) begin
            e_sel[j] = 0; e_rd[j] = 0; e_wr[j] = 0; e_busy[j] = 0;
            e_addr[j] = 0; e_ack[j] = 0; e_wd[j] = 0; e_rdv[j] = 0;
        end
        m_rd[0] = 0; m_rd[1] = 0;
        pref = 0; win = 0; ack_c = -1; cap_c = -1; next_free = 0;
        granted[0] = 0; granted[1] = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin adv(); mdl(); end
    endtask

    task automatic new_req(input int s);
        r_req[s]  = 1'b1;
        r_we[s]   = 1'($urandom_range(1, 0));
        r_addr[s] = 2'($urandom_range(3, 0));
        r_wd[s]   = 8'($urandom_range(255, 0));
    endtask

    logic [1:0] exp_ack;
    bit         in_rst;

    initial begin
        r_req = 0; r_we = 0; r_lock = 0;
        r_addr[0] = 0; r_addr[1] = 0; r_wd[0] = 0; r_wd[1] = 0;
        fifo_rdata_i = 8'h00;
        #1;
        chk("reset_state", {fifo_sel_o, fifo_read_o, fifo_write_o, fifo_addr_o, fifo_wdata_o,
            m0_ack_o, m1_ack_o, m0_rdata_o, m1_rdata_o, busy_o}, 32'h0);
        adv(); rst_i = 1'b0; mdl();
        idle(2);

        // Reset in the middle of a read (WAIT state).
        adv(); r_req[1] = 1; r_we[1] = 0; r_addr[1] = 2'd1; mdl();
        adv(); chk("t1_issue", {fifo_read_o, fifo_addr_o}, {1'b1, 2'd1}); mdl();
        adv(); chk("t1_busy", busy_o, 1'b1);
        rst_i = 1'b1; #1;
        chk("t1_rst_out", {fifo_sel_o, fifo_read_o, fifo_write_o, fifo_addr_o, fifo_wdata_o,
            m0_ack_o, m1_ack_o, m0_rdata_o, m1_rdata_o, busy_o}, 32'h0);
        r_req = 0; mdl_reset();
        adv(); rst_i = 1'b0; mdl();
        idle(6);

        // m0 write addr 2 data 0x5A alone.
        adv(); r_req[0] = 1; r_we[0] = 1; r_addr[0] = 2'd2; r_wd[0] = 8'h5A; mdl();
        adv(); chk("t2_strobe", {fifo_sel_o, fifo_write_o, fifo_read_o, fifo_addr_o, fifo_wdata_o},
                   {1'b1, 1'b1, 1'b0, 2'd2, 8'h5A}); mdl();
        adv(); chk("t2_ack", {m1_ack_o, m0_ack_o}, 2'b01); r_req[0] = 0; mdl();
        adv(); chk("t2_done", {busy_o, m0_ack_o, fifo_write_o}, 3'b000); mdl();
        idle(2);

        // m1 read addr 1, data 0xC3 presented on the capture cycle only.
        for (int k = 0; k < 8; k++) begin
            adv();
            if (k == 0) begin r_req[1] = 1; r_we[1] = 0; r_addr[1] = 2'd1; end
            if (k == 1) chk("t3_issue", {fifo_read_o, fifo_addr_o}, {1'b1, 2'd1});
            if (k == 4) chk("t3_early", m1_ack_o, 1'b0);
            if (k == 5) begin
                chk("t3_ack", {m1_ack_o, m1_rdata_o}, {1'b1, 8'hC3});
                r_req[1] = 0;
            end
            fifo_rdata_i = (k == 4) ? 8'hC3 : 8'h11;
            mdl();
        end

        // Both write continuously: alternation m0,m1,m0,m1, acks 3 apart.
        r_we = 2'b11; r_addr[0] = 2'd0; r_addr[1] = 2'd3; r_wd[0] = 8'hA0; r_wd[1] = 8'hB1;
        for (int k = 0; k < 13; k++) begin
            adv();
            if (k == 0) r_req = 2'b11;
            exp_ack = (k == 2 || k == 8) ? 2'b01 : (k == 5 || k == 11) ? 2'b10 : 2'b00;
            chk("t4_rr", {m1_ack_o, m0_ack_o}, exp_ack);
            if (k == 11) r_req = 2'b00;
            mdl();
        end

        // m0 holds lock while both request; lock dropped before the 4th ack.
        r_lock = 2'b01;
        for (int k = 0; k < 16; k++) begin
            adv();
            if (k == 0) r_req = 2'b11;
            if (k == 9) r_lock = 2'b00;
`ifdef FIFO_ARB_LOCK_EN
            exp_ack = (k == 2 || k == 5 || k == 8 || k == 11) ? 2'b01 : (k == 14) ? 2'b10 : 2'b00;
`else
            exp_ack = (k == 2 || k == 8 || k == 14) ? 2'b01 : (k == 5 || k == 11) ? 2'b10 : 2'b00;
`endif
            chk("t5_lock", {m1_ack_o, m0_ack_o}, exp_ack);
            if (k == 14) r_req = 2'b00;
            mdl();
        end

        // m0 read drops req during WAIT; ack still comes, then m1 is served.
        for (int k = 0; k < 10; k++) begin
            adv();
            if (k == 0) begin r_req[0] = 1; r_we[0] = 0; r_addr[0] = 2'd3; end
            if (k == 1) begin r_req[1] = 1; r_we[1] = 1; r_addr[1] = 2'd0; r_wd[1] = 8'h77; end
            if (k == 2) r_req[0] = 0;
            exp_ack = (k == 5) ? 2'b01 : (k == 8) ? 2'b10 : 2'b00;
            chk("t6_drop", {m1_ack_o, m0_ack_o}, exp_ack);
            if (k == 8) r_req[1] = 0;
            fifo_rdata_i = 8'($urandom_range(255, 0));
            mdl();
        end

        // Randomized traffic.
        in_rst = 0;
        for (int n = 0; n < 2500; n++) begin
            adv();
            if (in_rst) begin
                rst_i = 1'b0;
                in_rst = 0;
            end else if ($urandom_range(599, 0) == 0) begin
                rst_i = 1'b1;
                in_rst = 1;
                r_req = 0;
                mdl_reset();
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (e_ack[cyc][s]) begin
                        if ($urandom_range(1, 0) == 1) new_req(s);
                        else r_req[s] = 1'b0;
                    end else if (!r_req[s]) begin
                        if ($urandom_range(3, 0) == 0) new_req(s);
                    end else if (granted[s] && $urandom_range(15, 0) == 0) begin
                        r_req[s] = 1'b0;
                    end
                end
            end
            r_lock = 2'($urandom_range(3, 0));
            fifo_rdata_i = 8'($urandom_range(255, 0));
            mdl();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
